// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath strobe.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCondEq,
    output logic       PCWriteCondNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       ZeroExt,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_ALUWB    = 4'd7,
        S_ITYPE_EX = 4'd8,
        S_ITYPE_WB = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] imm_aluop;
    logic       imm_zext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // I-type ALU code and extension mode, shared by ITYPE_EX and ITYPE_WB.
    always_comb begin
        imm_aluop = 3'b000;
        imm_zext  = 1'b0;
        case (Opcode)
            OP_ANDI: begin imm_aluop = 3'b011; imm_zext = 1'b1; end
            OP_ORI:  begin imm_aluop = 3'b001; imm_zext = 1'b1; end
            OP_LUI:  begin imm_aluop = 3'b010; imm_zext = 1'b1; end
            default: begin imm_aluop = 3'b000; imm_zext = 1'b0; end
        endcase
    end

    // MemReady handshake: in FETCH, MEMREAD and MEMWRITE the access strobes are
    // held and the state holds until MemReady is seen high at a rising edge.
    always_comb begin
        state_d       = S_FETCH;
        PCWrite       = 1'b0;
        PCWriteCondEq = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemToReg      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ZeroExt       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALUOp         = 3'b000;
        IllegalOp     = 1'b0;
        State         = 4'd0;
        if (!reset) begin
            State = state_q;
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                    state_d = MemReady ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (Opcode)
                        OP_LW, OP_SW:                    state_d = S_MEMADR;
                        OP_R:                            state_d = S_RTYPE_EX;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_ITYPE_EX;
                        OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
                        OP_J:                            state_d = S_JUMP;
                        default:                         state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = (Opcode == OP_SW) ? 3'b110 : 3'b101;
                    state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    state_d = MemReady ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_MEMWRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    state_d  = MemReady ? S_FETCH : S_MEMWRITE;
                end
                S_RTYPE_EX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 3'b111;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_ITYPE_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = imm_aluop;
                    ZeroExt = imm_zext;
                    state_d = S_ITYPE_WB;
                end
                S_ITYPE_WB: begin
                    RegWrite = 1'b1;
                    ALUOp    = imm_aluop;
                    ZeroExt  = imm_zext;
                    state_d  = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA       = 1'b1;
                    ALUOp         = 3'b100;
                    PCSource      = 2'b01;
                    PCWriteCondEq = (Opcode == OP_BEQ);
                    PCWriteCondNe = (Opcode == OP_BNE);
                    state_d       = S_FETCH;
                end
                S_JUMP: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                    state_d  = S_FETCH;
                end
                S_TRAP: begin
                    IllegalOp = 1'b1;
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model builds the expected
// per-cycle strobe vector; a negedge monitor compares the DUT against it.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, ceq, cne, iord, mrd, mwr, irw, rdst, m2r, rw, srca, zext;
    logic [1:0] srcb, pcs;
    logic [2:0] aluop;
    logic       ill;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic       MemReady = 1'b1;
  logic       PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemToReg, RegWrite, ALUSrcA, ZeroExt, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;

  logic [23:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [5:0]  legal_ops[10] = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
                                 OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCondEq(PCWriteCondEq), .PCWriteCondNe(PCWriteCondNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ZeroExt(ZeroExt), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  logic [23:0] dut_o;
  assign dut_o = {State, PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite,
                  IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, ZeroExt, ALUSrcB,
                  PCSource, ALUOp, IllegalOp};

  task automatic check_out(input logic [23:0] got, input logic [23:0] exp, input string nm);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", nm, $time, got, exp);
    end
  endtask

  // Monitor: one expected vector per driven cycle, compared mid-cycle.
  logic [23:0] mon_exp;
  string       mon_name;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      check_out(dut_o, mon_exp, mon_name);
    end
  end

  task automatic cycle(input logic rst, input logic rdy, input logic [5:0] op,
                       input out_t e, input string nm);
    @(posedge clk);
    #1;
    reset    = rst;
    MemReady = rdy;
    Opcode   = op;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level reference: what each cycle of one instruction must show.
  task automatic run_instr(input logic [5:0] op, input int fetch_waits, input int mem_waits);
    out_t e;
    for (int i = 0; i < fetch_waits; i++) begin
      e = '0; e.mrd = 1; e.srcb = 2'b01;
      cycle(0, 0, op, e, "fetch_wait");
    end
    e = '0; e.mrd = 1; e.srcb = 2'b01; e.irw = 1; e.pcw = 1;
    cycle(0, 1, op, e, "fetch");
    e = '0; e.st = 4'd1; e.srcb = 2'b11;
    cycle(0, rnd_bit(), op, e, "decode");
    case (op)
      OP_LW, OP_SW: begin
        e = '0; e.st = 4'd2; e.srca = 1; e.srcb = 2'b10;
        e.aluop = (op == OP_LW) ? 3'b101 : 3'b110;
        cycle(0, rnd_bit(), op, e, "memadr");
        if (op == OP_LW) begin
          e = '0; e.st = 4'd3; e.mrd = 1; e.iord = 1;
          for (int i = 0; i < mem_waits; i++) cycle(0, 0, op, e, "memread_wait");
          cycle(0, 1, op, e, "memread");
          e = '0; e.st = 4'd4; e.m2r = 1; e.rw = 1;
          cycle(0, rnd_bit(), op, e, "memwb");
        end else begin
          e = '0; e.st = 4'd5; e.mwr = 1; e.iord = 1;
          for (int i = 0; i < mem_waits; i++) cycle(0, 0, op, e, "memwrite_wait");
          cycle(0, 1, op, e, "memwrite");
        end
      end
      OP_R: begin
        e = '0; e.st = 4'd6; e.srca = 1; e.aluop = 3'b111;
        cycle(0, rnd_bit(), op, e, "rtype_ex");
        e = '0; e.st = 4'd7; e.rdst = 1; e.rw = 1;
        cycle(0, rnd_bit(), op, e, "aluwb");
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
        logic [2:0] a;
        a = (op == OP_ANDI) ? 3'b011 : (op == OP_ORI) ? 3'b001 :
            (op == OP_LUI) ? 3'b010 : 3'b000;
        e = '0; e.st = 4'd8; e.srca = 1; e.srcb = 2'b10; e.aluop = a;
        e.zext = (op != OP_ADDI);
        cycle(0, rnd_bit(), op, e, "itype_ex");
        e = '0; e.st = 4'd9; e.rw = 1; e.aluop = a; e.zext = (op != OP_ADDI);
        cycle(0, rnd_bit(), op, e, "itype_wb");
      end
      OP_BEQ, OP_BNE: begin
        e = '0; e.st = 4'd10; e.srca = 1; e.aluop = 3'b100; e.pcs = 2'b01;
        e.ceq = (op == OP_BEQ); e.cne = (op == OP_BNE);
        cycle(0, rnd_bit(), op, e, "branch");
      end
      OP_J: begin
        e = '0; e.st = 4'd11; e.pcs = 2'b10; e.pcw = 1;
        cycle(0, rnd_bit(), op, e, "jump");
      end
      default: begin
        e = '0; e.st = 4'd12; e.ill = 1;
        cycle(0, rnd_bit(), op, e, "trap");
      end
    endcase
  endtask

  initial begin
    out_t e;
    logic [5:0] op;
    reset = 1'b1; MemReady = 1'b1;
    cycle(1, 1, OP_R, '0, "reset_hold");
    #1;
    check_out(dut_o, 24'd0, "reset_state_direct");
    for (int i = 0; i < 2; i++) cycle(1, 1, OP_R, '0, "reset_hold");

    // Directed instruction mix, including memory wait states.
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 2);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BNE, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_ORI, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(OP_BEQ, 2, 0);
    run_instr(OP_SW, 1, 3);

    // Reset during the MEMWRITE wait aborts the store.
    e = '0; e.mrd = 1; e.srcb = 2'b01; e.irw = 1; e.pcw = 1;
    cycle(0, 1, OP_SW, e, "abort_fetch");
    e = '0; e.st = 4'd1; e.srcb = 2'b11;
    cycle(0, 1, OP_SW, e, "abort_decode");
    e = '0; e.st = 4'd2; e.srca = 1; e.srcb = 2'b10; e.aluop = 3'b110;
    cycle(0, 1, OP_SW, e, "abort_memadr");
    e = '0; e.st = 4'd5; e.mwr = 1; e.iord = 1;
    cycle(0, 0, OP_SW, e, "abort_memwrite_wait");
    #1;
    check_out(dut_o, e, "memwrite_wait_held_direct");
    cycle(1, 0, OP_SW, '0, "reset_in_wait");
    #1;
    check_out(dut_o, 24'd0, "reset_in_wait_direct");
    run_instr(OP_ADDI, 0, 0);

    // Randomized instruction stream with random wait lengths.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 9)];
      else op = 6'($urandom_range(0, 63));
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) cycle(1, rnd_bit(), op, '0, "rand_reset");
    end

    @(posedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
